meta_buf_writer: RTL

Runtime loader and reader for one PE's meta buffer. It is the write side of the per-PE meta-data store. It consumes a broadcast configuration stream, captures only the segments addressed to its own `peId`, and writes them into a local RAM. It serves the PE's read port with the same registered, one-cycle read the PE already expects from its meta buffer, so the contents can be reloaded without resynthesis.

---
 rtl/meta_buf_writer.sv | 110 +++++++++++
 1 files changed

// File: rtl/meta_buf_writer.sv
// meta_buf_writer: captures broadcast configuration segments addressed to peId into a
// local meta RAM and serves the PE's registered read port. Option: META_WR_BYPASS_EN.
module meta_buf_writer #(
    parameter int addrLen = 10,
    parameter int dataLen = 16,
    parameter int peId    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [dataLen-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [addrLen-1:0] rd_addr,
    output logic [dataLen-1:0] data_out,
    output logic               busy,
    output logic               loaded,
    output logic               load_done
);
    localparam int SelW  = dataLen - addrLen;
    localparam int Depth = 1 << addrLen;
    localparam logic [SelW-1:0] PeSel = SelW'(peId);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [addrLen-1:0] remaining_q, remaining_d;
    logic [addrLen-1:0] wptr_q, wptr_d;
    logic               sel_q, sel_d;
    logic               loaded_q, load_done_q;
    logic [dataLen-1:0] data_q;
    logic [dataLen-1:0] mem [Depth];
    logic               xfer, wr_en, commit_hit;

    assign in_ready   = (state_q != COMMIT);
    assign busy       = (state_q != IDLE);
    assign loaded     = loaded_q;
    assign load_done  = load_done_q;
    assign data_out   = data_q;
    assign xfer       = in_valid && in_ready;
    assign wr_en      = (state_q == LOAD) && xfer && sel_q;
    assign commit_hit = (state_d == COMMIT) && sel_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        remaining_d = remaining_q;
        wptr_d      = wptr_q;
        sel_d       = sel_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sel_d       = (in_data[dataLen-1:addrLen] == PeSel);
                    remaining_d = in_data[addrLen-1:0];
                    wptr_d      = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wptr_d = wptr_q + addrLen'(1);
                    if (remaining_q == '0) state_d = COMMIT;
                    else remaining_d = remaining_q - addrLen'(1);
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wptr_q      <= '0;
            sel_q       <= 1'b0;
            loaded_q    <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wptr_q      <= wptr_d;
            sel_q       <= sel_d;
            loaded_q    <= loaded_q | commit_hit;
            load_done_q <= commit_hit;
        end
    end

    // NOTE: the RAM has no reset; contents survive reset and are masked by loaded_q on reads.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= in_data;
    end

    // Read path runs every cycle; a same-address write lands after this read samples (read-first).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (!loaded_q) begin
            data_q <= '0;
`ifdef META_WR_BYPASS_EN
        end else if (wr_en && (wptr_q == rd_addr)) begin
            data_q <= in_data;
`endif
        end else begin
            data_q <= mem[rd_addr];
        end
    end
endmodule
